// File: rtl/mac_wr_pair_joiner.sv
// Joins an address stream and a data stream into one FIFO-buffered pair stream
// feeding the MAC write port, under a length-controlled job FSM with done reporting.
module mac_wr_pair_joiner #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             enable_i,
    input  logic                             start_i,
    input  logic [LEN_WIDTH-1:0]             len_i,
    input  logic                             a_valid_i,
    output logic                             a_ready_o,
    input  logic [ADDR_WIDTH-1:0]            a_data_i,
    input  logic                             b_valid_i,
    output logic                             b_ready_o,
    input  logic [DATA_WIDTH-1:0]            b_data_i,
    output logic                             c_valid_o,
    input  logic                             c_ready_i,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] c_data_o,
    output logic [(ADDR_WIDTH+DATA_WIDTH+7)/8-1:0] c_strb_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [LEN_WIDTH-1:0]             cnt_o
);

    localparam int unsigned PW = ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [AW:0]          wptr_q, rptr_q;
    logic [PW-1:0]        mem_q [DEPTH];
    logic                 empty, full, push, pop;

    // The extra wrap bit tells full from empty when the index bits match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign push      = (state_q == RUN) && a_valid_i && b_valid_i && !full && enable_i && !clear_i;
    assign c_valid_o = !empty && enable_i;
    assign pop       = c_valid_o && c_ready_i;

    assign a_ready_o = push;
    assign b_ready_o = push;
    assign c_data_o  = mem_q[rptr_q[AW-1:0]];
    assign c_strb_o  = '1;
    assign busy_o    = (state_q == RUN) || (state_q == DRAIN);
    assign done_o    = (state_q == DONE) && !clear_i;
    assign cnt_o     = cnt_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {b_data_i, a_data_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // A low enable holds the whole job state; clear overrides everything.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            state_d = IDLE;
            len_d   = '0;
            cnt_d   = '0;
        end else if (enable_i) begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        len_d   = len_i;
                        cnt_d   = '0;
                        state_d = (len_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (push) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == len_q) state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_wr_pair_joiner.sv
// Directed self-checking bench for mac_wr_pair_joiner: one task per scenario,
// expected pairs and handshake patterns are worked out by hand from the stimulus.
module tb_mac_wr_pair_joiner;

    localparam int LW = 16;

    logic          clk, rstN, clear, enable, start;
    logic [LW-1:0] len;
    logic          aValid, aReady, bValid, bReady, cValid, cReady;
    logic [31:0]   aData, bData;
    logic [63:0]   cData;
    logic [7:0]    cStrb;
    logic          busy, done;
    logic [LW-1:0] cnt;

    int total = 0;
    int bad   = 0;

    mac_wr_pair_joiner #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .LEN_WIDTH(LW)
    ) dut (
        .clk_i(clk), .rst_ni(rstN), .clear_i(clear), .enable_i(enable),
        .start_i(start), .len_i(len),
        .a_valid_i(aValid), .a_ready_o(aReady), .a_data_i(aData),
        .b_valid_i(bValid), .b_ready_o(bReady), .b_data_i(bData),
        .c_valid_o(cValid), .c_ready_i(cReady), .c_data_o(cData), .c_strb_o(cStrb),
        .busy_o(busy), .done_o(done), .cnt_o(cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        aValid = 0; bValid = 0; start = 0; clear = 0; enable = 1;
        cReady = 1; aData = '0; bData = '0; len = '0;
    endtask

    task automatic startJob(input logic [LW-1:0] l);
        start = 1; len = l;
        @(negedge clk);
        nextCycle();
        start = 0;
    endtask

    task automatic test_reset();
        idleInputs();
        rstN = 0; aValid = 1; bValid = 1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%0b want=0", done); end
        total++; if (cValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_cvalid got=%0b want=0", cValid); end
        total++; if (aReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_aready got=%0b want=0", aReady); end
        total++; if (bReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_bready got=%0b want=0", bReady); end
        total++; if (cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d want=0", cnt); end
        total++; if (cStrb !== 8'hFF) begin bad++; $display("[TB] FAIL reset_strb got=%h want=ff", cStrb); end
        @(posedge clk); #1;
        rstN = 1; aValid = 0; bValid = 0;
        nextCycle();
    endtask

    task automatic test_basic();
        logic [31:0] lo, hi;
        aValid = 1; bValid = 1; aData = 32'h10; bData = 32'hA0; cReady = 1;
        start = 1; len = 4;
        @(negedge clk);
        total++; if (aReady !== 1'b0) begin bad++; $display("[TB] FAIL basic_idle_ready got=%0b want=0", aReady); end
        nextCycle();
        start = 0;
        for (int r = 0; r < 4; r++) begin
            aData = 32'h10 + r; bData = 32'hA0 + r;
            @(negedge clk);
            total++; if (aReady !== 1'b1 || bReady !== 1'b1) begin bad++; $display("[TB] FAIL basic_ready r=%0d got=%0b%0b want=11", r, aReady, bReady); end
            total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy r=%0d got=%0b want=1", r, busy); end
            if (r > 0) begin
                lo = 32'h10 + r - 1; hi = 32'hA0 + r - 1;
                total++; if (cValid !== 1'b1 || cData !== {hi, lo}) begin bad++; $display("[TB] FAIL basic_pair r=%0d got=%0b/%h want=1/%h", r, cValid, cData, {hi, lo}); end
            end
            nextCycle();
        end
        @(negedge clk);
        total++; if (aReady !== 1'b0) begin bad++; $display("[TB] FAIL basic_drain_ready got=%0b want=0", aReady); end
        total++; if (cValid !== 1'b1 || cData !== {32'hA3, 32'h13}) begin bad++; $display("[TB] FAIL basic_last got=%0b/%h want=1/%h", cValid, cData, {32'hA3, 32'h13}); end
        total++; if (cnt !== 16'd4) begin bad++; $display("[TB] FAIL basic_cnt got=%0d want=4", cnt); end
        aValid = 0; bValid = 0;
        nextCycle();
        @(negedge clk);
        total++; if (cValid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_empty got=v%0b d%0b b%0b want=v0 d0 b1", cValid, done, busy); end
        nextCycle();
        @(negedge clk);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_done got=d%0b b%0b want=d1 b0", done, busy); end
        nextCycle();
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0 || cnt !== 16'd4) begin bad++; $display("[TB] FAIL basic_after got=d%0b b%0b c%0d want=d0 b0 c4", done, busy, cnt); end
        nextCycle();
    endtask

    task automatic test_skewed();
        int pushes = 0, received = 0;
        bit doneSeen = 0, expRdy;
        logic [31:0] lo, hi;
        cReady = 1;
        startJob(3);
        for (int r = 0; r < 20 && !doneSeen; r++) begin
            aValid = 1;
            bValid = (r % 3 == 0) && (pushes < 3);
            aData = 32'h20 + pushes; bData = 32'hB0 + pushes;
            expRdy = bValid;
            @(negedge clk);
            total++; if (aReady !== expRdy || bReady !== expRdy) begin bad++; $display("[TB] FAIL skew_ready r=%0d got=%0b%0b want=%0b", r, aReady, bReady, expRdy); end
            if (cValid) begin
                lo = 32'h20 + received; hi = 32'hB0 + received;
                total++; if (cData !== {hi, lo}) begin bad++; $display("[TB] FAIL skew_pair n=%0d got=%h want=%h", received, cData, {hi, lo}); end
                received++;
            end
            if (done) doneSeen = 1;
            nextCycle();
            if (expRdy) pushes++;
        end
        aValid = 0; bValid = 0;
        total++; if (!doneSeen) begin bad++; $display("[TB] FAIL skew_done got=timeout want=done"); end
        total++; if (received != 3) begin bad++; $display("[TB] FAIL skew_count got=%0d want=3", received); end
        total++; if (cnt !== 16'd3) begin bad++; $display("[TB] FAIL skew_cnt got=%0d want=3", cnt); end
    endtask

    task automatic test_backpressure();
        int pushes = 0, received = 0;
        bit doneSeen = 0;
        logic [8:0] rdyPat;
        logic [31:0] lo, hi;
        rdyPat = 9'b110001111;
        cReady = 0;
        startJob(6);
        for (int r = 0; r < 9; r++) begin
            aValid = 1; bValid = 1;
            aData = 32'h30 + pushes; bData = 32'hC0 + pushes;
            cReady = (r >= 6);
            @(negedge clk);
            total++; if (aReady !== rdyPat[r]) begin bad++; $display("[TB] FAIL bp_ready r=%0d got=%0b want=%0b", r, aReady, rdyPat[r]); end
            if (r == 5) begin
                total++; if (cnt !== 16'd4) begin bad++; $display("[TB] FAIL bp_cnt_full got=%0d want=4", cnt); end
            end
            if (cValid && cReady) begin
                lo = 32'h30 + received; hi = 32'hC0 + received;
                total++; if (cData !== {hi, lo}) begin bad++; $display("[TB] FAIL bp_pair n=%0d got=%h want=%h", received, cData, {hi, lo}); end
                received++;
            end
            nextCycle();
            if (rdyPat[r]) pushes++;
        end
        for (int k = 0; k < 20 && !doneSeen; k++) begin
            @(negedge clk);
            total++; if (aReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain_ready k=%0d got=%0b want=0", k, aReady); end
            if (cValid) begin
                lo = 32'h30 + received; hi = 32'hC0 + received;
                total++; if (cData !== {hi, lo}) begin bad++; $display("[TB] FAIL bp_pair n=%0d got=%h want=%h", received, cData, {hi, lo}); end
                received++;
            end
            if (done) begin
                doneSeen = 1;
                total++; if (received != 6 || cValid !== 1'b0) begin bad++; $display("[TB] FAIL bp_done_early got=%0d/%0b want=6/0", received, cValid); end
            end
            nextCycle();
        end
        aValid = 0; bValid = 0;
        total++; if (!doneSeen) begin bad++; $display("[TB] FAIL bp_done got=timeout want=done"); end
        total++; if (cnt !== 16'd6) begin bad++; $display("[TB] FAIL bp_cnt got=%0d want=6", cnt); end
    endtask

    task automatic test_enable_freeze();
        int pushes = 0, received = 0;
        bit doneSeen = 0, expRdy;
        logic [31:0] lo, hi;
        cReady = 1;
        startJob(4);
        for (int r = 0; r < 30 && !doneSeen; r++) begin
            enable = !(r >= 2 && r < 7);
            aValid = (pushes < 4); bValid = (pushes < 4);
            aData = 32'h40 + pushes; bData = 32'hD0 + pushes;
            expRdy = enable && (pushes < 4);
            @(negedge clk);
            total++; if (aReady !== expRdy) begin bad++; $display("[TB] FAIL en_ready r=%0d got=%0b want=%0b", r, aReady, expRdy); end
            if (!enable) begin
                total++; if (cValid !== 1'b0 || cnt !== 16'd2) begin bad++; $display("[TB] FAIL en_freeze r=%0d got=v%0b c%0d want=v0 c2", r, cValid, cnt); end
            end
            if (cValid) begin
                lo = 32'h40 + received; hi = 32'hD0 + received;
                total++; if (cData !== {hi, lo}) begin bad++; $display("[TB] FAIL en_pair n=%0d got=%h want=%h", received, cData, {hi, lo}); end
                received++;
            end
            if (done) doneSeen = 1;
            nextCycle();
            if (expRdy) pushes++;
        end
        enable = 1; aValid = 0; bValid = 0;
        total++; if (!doneSeen) begin bad++; $display("[TB] FAIL en_done got=timeout want=done"); end
        total++; if (received != 4 || cnt !== 16'd4) begin bad++; $display("[TB] FAIL en_count got=%0d/%0d want=4/4", received, cnt); end
    endtask

    task automatic test_clear_mid_job();
        bit doneSeen = 0;
        cReady = 0;
        startJob(8);
        for (int r = 0; r < 3; r++) begin
            aValid = 1; bValid = 1; aData = 32'h50 + r; bData = 32'hE0 + r;
            cReady = (r == 1);
            @(negedge clk);
            total++; if (aReady !== 1'b1) begin bad++; $display("[TB] FAIL clr_push r=%0d got=%0b want=1", r, aReady); end
            nextCycle();
        end
        cReady = 0; clear = 1;
        @(negedge clk);
        total++; if (cnt !== 16'd3 || cValid !== 1'b1) begin bad++; $display("[TB] FAIL clr_before got=c%0d v%0b want=c3 v1", cnt, cValid); end
        total++; if (aReady !== 1'b0) begin bad++; $display("[TB] FAIL clr_ready got=%0b want=0", aReady); end
        nextCycle();
        clear = 0; aValid = 0; bValid = 0; cReady = 1;
        @(negedge clk);
        total++; if (cValid !== 1'b0 || cnt !== 16'd0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL clr_after got=v%0b c%0d b%0b want=v0 c0 b0", cValid, cnt, busy); end
        for (int k = 0; k < 3; k++) begin
            total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL clr_no_done k=%0d got=%0b want=0", k, done); end
            nextCycle();
            @(negedge clk);
        end
        nextCycle();
        startJob(1);
        aValid = 1; bValid = 1; aData = 32'h55; bData = 32'hE5;
        @(negedge clk);
        total++; if (aReady !== 1'b1) begin bad++; $display("[TB] FAIL clr_new_push got=%0b want=1", aReady); end
        nextCycle();
        aValid = 0; bValid = 0;
        @(negedge clk);
        total++; if (cValid !== 1'b1 || cData !== {32'hE5, 32'h55}) begin bad++; $display("[TB] FAIL clr_new_pair got=%0b/%h want=1/%h", cValid, cData, {32'hE5, 32'h55}); end
        for (int k = 0; k < 10 && !doneSeen; k++) begin
            nextCycle();
            @(negedge clk);
            if (done) doneSeen = 1;
        end
        total++; if (!doneSeen || cnt !== 16'd1) begin bad++; $display("[TB] FAIL clr_new_done got=%0b/%0d want=1/1", doneSeen, cnt); end
        nextCycle();
    endtask

    task automatic test_len_zero();
        aValid = 1; bValid = 1;
        startJob(0);
        @(negedge clk);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL len0_done got=d%0b b%0b want=d1 b0", done, busy); end
        total++; if (aReady !== 1'b0 || cnt !== 16'd0) begin bad++; $display("[TB] FAIL len0_ready got=r%0b c%0d want=r0 c0", aReady, cnt); end
        nextCycle();
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0 || aReady !== 1'b0) begin bad++; $display("[TB] FAIL len0_after got=d%0b b%0b r%0b want=0 0 0", done, busy, aReady); end
        aValid = 0; bValid = 0;
        nextCycle();
    endtask

    task automatic test_start_in_run();
        int pushes = 0, received = 0;
        bit doneSeen = 0;
        logic [31:0] lo, hi;
        cReady = 1;
        startJob(3);
        for (int k = 0; k < 20 && !doneSeen; k++) begin
            aValid = (pushes < 3); bValid = (pushes < 3);
            aData = 32'h60 + pushes; bData = 32'hF0 + pushes;
            start = (k == 1); len = (k == 1) ? 16'd9 : 16'd3;
            @(negedge clk);
            if (cValid) begin
                lo = 32'h60 + received; hi = 32'hF0 + received;
                total++; if (cData !== {hi, lo}) begin bad++; $display("[TB] FAIL run_start_pair n=%0d got=%h want=%h", received, cData, {hi, lo}); end
                received++;
            end
            if (done) doneSeen = 1;
            nextCycle();
            if (aValid) pushes++;
        end
        start = 0; aValid = 0; bValid = 0;
        total++; if (!doneSeen || received != 3 || cnt !== 16'd3) begin bad++; $display("[TB] FAIL run_start_ignored got=d%0b n%0d c%0d want=d1 n3 c3", doneSeen, received, cnt); end
    endtask

    task automatic test_async_reset();
        cReady = 0;
        startJob(2);
        for (int r = 0; r < 2; r++) begin
            aValid = 1; bValid = 1; aData = 32'h70 + r; bData = 32'h80 + r;
            nextCycle();
        end
        @(negedge clk);
        total++; if (busy !== 1'b1 || cValid !== 1'b1) begin bad++; $display("[TB] FAIL ar_drain got=b%0b v%0b want=b1 v1", busy, cValid); end
        #1 rstN = 0;
        #1;
        total++; if (busy !== 1'b0 || cValid !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL ar_outputs got=b%0b v%0b d%0b want=0 0 0", busy, cValid, done); end
        total++; if (cnt !== 16'd0 || aReady !== 1'b0) begin bad++; $display("[TB] FAIL ar_cnt got=c%0d r%0b want=c0 r0", cnt, aReady); end
        @(posedge clk); #1;
        rstN = 1; cReady = 1;
        @(negedge clk);
        total++; if (aReady !== 1'b0 || busy !== 1'b0 || cValid !== 1'b0) begin bad++; $display("[TB] FAIL ar_idle got=r%0b b%0b v%0b want=0 0 0", aReady, busy, cValid); end
        aValid = 0; bValid = 0;
        nextCycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skewed();
        test_backpressure();
        test_enable_freeze();
        test_clear_mid_job();
        test_len_zero();
        test_start_in_run();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_wr_pair_joiner.md
# mac_wr_pair_joiner

Parametrised join-and-buffer stage between the streamer and the MAC engine's write port. It replaces the fixed pair of independent 32-bit address/data streams and the hard-wired engine enable with a joined, FIFO-buffered pair stream. The stage uses configurable widths and depth, honours a real enable and clear, and runs a length-controlled job sequence that reports completion to the controller. It sits between `mac_streamer` sources and the engine's write-side sink.

## Interface
- ADDR_WIDTH, 32, width of address stream `a_i`
- DATA_WIDTH, 32, width of data stream `b_i`
- DEPTH, 4, FIFO entries; power of two, ≥2
- LEN_WIDTH, 16, width of job length and pair counter

- clk_i  in  1  single clock; all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous clear; priority over all other inputs
- enable_i  in  1  global enable; low freezes push and pop
- start_i  in  1  job start pulse; sampled in IDLE only
- len_i  in  LEN_WIDTH  number of pairs in the job, latched on start
- a_i  hwpe_stream_intf_stream.sink  ADDR_WIDTH  address stream (valid/ready/data)
- b_i  hwpe_stream_intf_stream.sink  DATA_WIDTH  data stream
- c_o  hwpe_stream_intf_stream.source  ADDR_WIDTH+DATA_WIDTH  joined pair, data = {b.data, a.data}
- busy_o  out  1  high in RUN or DRAIN
- done_o  out  1  one-cycle completion pulse
- cnt_o  out  LEN_WIDTH  pairs accepted in current job

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start_i, latch len_i and zero cnt_o.
  - If len_i == 0, go to DONE; otherwise go to RUN.
- RUN:
  - Push occurs when a.valid & b.valid & !full & enable_i.
  - a.ready = b.ready = that push condition (joined handshake; the two streams are consumed together or not at all).
  - Each push increments cnt_o.
  - When the push brings cnt_o to len, go to DRAIN.
- DRAIN: no new pushes (a.ready = b.ready = 0). Go to DONE when the FIFO is empty.
- DONE: done_o = 1 for exactly one cycle, then return to IDLE. cnt_o holds its final value until the next start_i.
- Outside RUN, a.ready and b.ready are 0; c_o keeps draining.
- FIFO:
  - DEPTH entries, registered, pointer-based with an extra wrap bit.
  - c.valid = !empty & enable_i.
  - Pop occurs on c.valid & c.ready.
  - Ordering is strictly FIFO.
- Push when full is not allowed, even if a pop occurs in the same cycle (ready depends on full only, not on c.ready).
- Simultaneous push and pop when not full and not empty: occupancy is unchanged and both complete.
- enable_i low: no push, no pop, c.valid = 0. FSM state, cnt_o and FIFO contents are held.
- start_i outside IDLE is ignored.
- clear_i:
  - Empties the FIFO and zeroes cnt_o and the latched length.
  - FSM goes to IDLE; done_o = 0 that cycle.
  - Applied mid-job, it aborts the job with no done_o.
- c.strb is all ones.

## Timing
- Reset values: state IDLE, FIFO empty, cnt_o 0, busy_o 0, done_o 0, c.valid 0, a.ready 0, b.ready 0.
- Latency: a pair pushed in cycle t is visible on c_o with valid in cycle t+1. There is no combinational path from a/b to c.
- Throughput: one pair per cycle sustained while c.ready = 1.
- busy_o rises the cycle after start_i. done_o pulses the cycle after the FIFO empties in DRAIN.
- With len_i == 0: done_o is high the cycle after start_i, and busy_o never rises.
- cnt_o wraps are impossible by construction (len ≤ 2^LEN_WIDTH−1).
- Asynchronous reset mid-job returns all outputs to reset values immediately. The next job needs a new start_i.

## Test plan
- Basic job:
  - Stimulus: len=4, both streams always valid with a.data=0x10..0x13 and b.data=0xA0..0xA3, c.ready=1.
  - Response: c.data = {0xA0,0x10}..{0xA3,0x13} on four consecutive cycles starting one cycle after the first push, cnt_o=4, done_o a single pulse, busy_o low afterwards.
- Skewed valids:
  - Stimulus: a.valid high throughout; b.valid high only on every third cycle; len=3.
  - Response: a.ready high only in cycles where b.valid is high, and exactly 3 pairs emitted.
- Backpressure:
  - Stimulus: DEPTH=4, c.ready=0, len=6.
  - Response: exactly 4 pushes, then a.ready=0. When c.ready rises, all 6 pairs arrive in order and done_o pulses only after the last pop.
- Enable freeze:
  - Stimulus: drop enable_i for 5 cycles mid-job.
  - Response: c.valid=0, no push, cnt_o unchanged; the job resumes and completes with correct order.
- Clear mid-job:
  - Stimulus: with 2 entries buffered and cnt=3 of len=8, pulse clear_i.
  - Response: next cycle FIFO empty, cnt_o=0, busy_o=0, no done_o. A new start_i with len=1 completes normally.
- Edge cases:
  - len_i=0 → done_o pulses the cycle after start_i, and no ready is asserted.
  - start_i during RUN is ignored.
  - Async reset during DRAIN → all outputs go to reset values.
